// File: rtl/axi_mem_responder_if.sv
// AXI4 bus bundle between an AXI master and the memory responder.
// Handshake rule for every channel: a transfer occurs on the rising clk edge where valid && ready are both 1; a source holds valid and its payload stable until that edge, and ready may change freely.
interface axi_mem_responder_if #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;

  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_mem_responder.sv
// AXI4 slave memory target: one read burst and one write burst in flight at a time on
// independent FSMs, backed by a byte-strobed word memory that is not reset.
module axi_mem_responder #(
  parameter int ID_WIDTH     = 13,
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = 64,
  parameter int STRB_WIDTH   = DATA_WIDTH / 8,
  parameter int MEM_WORDS    = 4096,
  parameter int READ_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  axi_mem_responder_if.slave   s_axi,
  output logic [1:0]           r_state_dbg,
  output logic [1:0]           w_state_dbg
);

  localparam int OFF_W = $clog2(STRB_WIDTH);
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [2:0] MAX_SIZE = 3'(OFF_W);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_WAIT  = 2'd1;
  localparam logic [1:0] R_BURST = 2'd2;

  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_DATA  = 2'd1;
  localparam logic [1:0] W_RESP  = 2'd2;

  function automatic logic [ADDR_WIDTH-1:0] step_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [2:0] size,
                                                      input logic [1:0] burst);
    return (burst == BURST_INCR) ? a + (ADDR_WIDTH'(1) << size) : a;
  endfunction

  function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst);
    return ((burst != BURST_FIXED) && (burst != BURST_INCR)) || (size > MAX_SIZE);
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // ---------------------------------------------------------------- read path
  logic [1:0]            r_state;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_addr_next;
  logic [7:0]            r_len;
  logic [7:0]            r_beat;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_err;
  logic [LAT_W-1:0]      r_lat;
  logic [IDX_W-1:0]      r_idx_cur;
  logic [IDX_W-1:0]      r_idx_next;

  logic                  arready_q;
  logic                  rvalid_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic                  rlast_q;

  logic ar_hs;
  logic r_hs;

  assign ar_hs       = s_axi.arvalid && arready_q;
  assign r_hs        = rvalid_q && s_axi.rready;
  assign r_addr_next = step_addr(r_addr, r_size, r_burst);
  assign r_idx_cur   = r_addr[OFF_W +: IDX_W];
  assign r_idx_next  = r_addr_next[OFF_W +: IDX_W];

  // Beats sample mem with a nonblocking read, so a same-cycle write is seen one beat later.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= R_IDLE;
      r_id      <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_beat    <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_err     <= 1'b0;
      r_lat     <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rlast_q   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (ar_hs) begin
            r_id      <= s_axi.arid;
            r_addr    <= s_axi.araddr;
            r_len     <= s_axi.arlen;
            r_size    <= s_axi.arsize;
            r_burst   <= s_axi.arburst;
            r_err     <= burst_err(s_axi.arsize, s_axi.arburst);
            r_lat     <= LAT_W'(READ_LATENCY - 1);
            arready_q <= 1'b0;
            r_state   <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_lat == '0) begin
            rvalid_q <= 1'b1;
            rid_q    <= r_id;
            rdata_q  <= r_err ? '0 : mem[r_idx_cur];
            rresp_q  <= r_err ? RESP_SLVERR : RESP_OKAY;
            rlast_q  <= (r_len == 8'd0);
            r_beat   <= 8'd0;
            r_state  <= R_BURST;
          end else begin
            r_lat <= r_lat - LAT_W'(1);
          end
        end
        R_BURST: begin
          if (r_hs) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              r_state   <= R_IDLE;
            end else begin
              r_addr  <= r_addr_next;
              r_beat  <= r_beat + 8'd1;
              rdata_q <= r_err ? '0 : mem[r_idx_next];
              rlast_q <= ((r_beat + 8'd1) == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rid     = rid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rlast   = rlast_q;

  // --------------------------------------------------------------- write path
  logic [1:0]            w_state;
  logic [ID_WIDTH-1:0]   w_id;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] w_addr_next;
  logic [7:0]            w_len;
  logic [7:0]            w_beat;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic                  w_err;
  logic [IDX_W-1:0]      w_idx;

  logic                  awready_q;
  logic                  wready_q;
  logic                  bvalid_q;
  logic [ID_WIDTH-1:0]   bid_q;
  logic [1:0]            bresp_q;

  logic aw_hs;
  logic w_hs;
  logic w_at_len;
  logic w_commit;

  assign aw_hs       = s_axi.awvalid && awready_q;
  assign w_hs        = s_axi.wvalid && wready_q;
  assign w_at_len    = (w_beat == w_len);
  assign w_addr_next = step_addr(w_addr, w_size, w_burst);
  assign w_idx       = w_addr[OFF_W +: IDX_W];
  assign w_commit    = reset_n && (w_state == W_DATA) && w_hs && !w_err;

  // Burst ends on wlast or on the len-th beat; disagreement between the two is reported as SLVERR.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      w_state   <= W_IDLE;
      w_id      <= '0;
      w_addr    <= '0;
      w_len     <= '0;
      w_beat    <= '0;
      w_size    <= '0;
      w_burst   <= '0;
      w_err     <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (aw_hs) begin
            w_id      <= s_axi.awid;
            w_addr    <= s_axi.awaddr;
            w_len     <= s_axi.awlen;
            w_size    <= s_axi.awsize;
            w_burst   <= s_axi.awburst;
            w_err     <= burst_err(s_axi.awsize, s_axi.awburst);
            w_beat    <= 8'd0;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_state   <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            if (s_axi.wlast || w_at_len) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bid_q    <= w_id;
              bresp_q  <= (w_err || (s_axi.wlast != w_at_len)) ? RESP_SLVERR : RESP_OKAY;
              w_state  <= W_RESP;
            end else begin
              w_beat <= w_beat + 8'd1;
              w_addr <= w_addr_next;
            end
          end
        end
        W_RESP: begin
          if (bvalid_q && s_axi.bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state   <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (s_axi.wstrb[i]) mem[w_idx][i*8 +: 8] <= s_axi.wdata[i*8 +: 8];
      end
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bid     = bid_q;
  assign s_axi.bresp   = bresp_q;

  assign r_state_dbg = r_state;
  assign w_state_dbg = w_state;

  // Memory attributes carry no meaning for this target.
  logic unused_attr;
  assign unused_attr = ^{s_axi.awlock, s_axi.awcache, s_axi.awprot,
                         s_axi.arlock, s_axi.arcache, s_axi.arprot};

endmodule

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview:
- AXI4 slave endpoint with an internal word-addressed memory. It sits at the far end of the bus that the core's cache interconnect drives.
- Services one read burst and one write burst at a time, on independent read and write paths.
- Used as the simulation and bring-up memory target for icache/dcache traffic. Read IDs are echoed, so ID-based routing (rid[0]) works unchanged.

Parameters:
- ID_WIDTH, 13, width of AXI ID fields
- ADDR_WIDTH, 64, AXI address width
- DATA_WIDTH, 64, data bus width; must be a power of two ≥ 8
- STRB_WIDTH, DATA_WIDTH/8, write-strobe width
- MEM_WORDS, 4096, memory depth in DATA_WIDTH words; power of two
- READ_LATENCY, 2, cycles from AR handshake to first rvalid; must be ≥ 1

Ports:
- clk in 1: clock
- reset_n in 1: synchronous, active-low reset
- s_axi_awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot in ID_WIDTH/ADDR_WIDTH/8/3/2/1/4/3: write address
- s_axi_awvalid in 1, s_axi_awready out 1
- s_axi_wdata in DATA_WIDTH, s_axi_wstrb in STRB_WIDTH, s_axi_wlast in 1, s_axi_wvalid in 1, s_axi_wready out 1
- s_axi_bid out ID_WIDTH, s_axi_bresp out 2, s_axi_bvalid out 1, s_axi_bready in 1
- s_axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot in ID_WIDTH/ADDR_WIDTH/8/3/2/1/4/3: read address
- s_axi_arvalid in 1, s_axi_arready out 1
- s_axi_rid out ID_WIDTH, s_axi_rdata out DATA_WIDTH, s_axi_rresp out 2, s_axi_rlast out 1, s_axi_rvalid out 1, s_axi_rready in 1

Behaviour:

Reset and ignored inputs:
- Clock is clk; reset is synchronous, active-low on reset_n.
- While reset_n=0, all outputs are registered 0 and both FSMs return to IDLE. This applies mid-burst: the burst is abandoned and no B or R completion is issued.
- Memory contents are not reset.
- awready and arready rise the first cycle after reset_n goes high.
- lock, cache and prot inputs are ignored.

Addressing:
- Word index = addr[$clog2(STRB_WIDTH) +: $clog2(MEM_WORDS)]. Upper bits are ignored, so the index wraps modulo MEM_WORDS.
- Per beat, a latched 64-bit address advances by (1<<size) for INCR (burst=2'b01) and holds for FIXED (2'b00).

Errors (SLVERR, 2'b10):
- Triggered by WRAP/reserved burst type, or size > $clog2(STRB_WIDTH).
- Reads with an error still return len+1 beats, with rdata=0 and rresp=SLVERR on every beat.
- Writes with an error commit nothing. Otherwise all responses are OKAY (2'b00).

Read FSM (R_IDLE, R_WAIT, R_BURST):
- R_IDLE: arready=1.
- On AR handshake at cycle T: latch id/addr/len/size/burst, load a latency counter, deassert arready, go to R_WAIT.
- R_WAIT: at cycle T+READ_LATENCY, assert rvalid with beat 0.
- R_BURST: rdata/rresp/rlast/rid are registered when each beat is loaded and held stable while rvalid=1 and rready=0. The next beat appears the cycle after each R handshake, giving 1 beat/cycle with rready held high.
- rlast=1 only on beat len.
- After the rlast handshake: rvalid=0, arready=1 next cycle (R_IDLE).

Write FSM (W_IDLE, W_DATA, W_RESP):
- W_IDLE: awready=1, wready=0. W beats are not accepted before AW.
- On AW handshake: latch fields, clear the beat counter, go to W_DATA.
- W_DATA: wready=1. Each W handshake writes the bytes with wstrb[i]=1 into the current word; other bytes are unchanged.
- The burst ends on a beat with wlast=1 OR when the beat count reaches len, whichever comes first. If wlast and count disagree, bresp=SLVERR (beats already written stay written).
- W_RESP: bvalid=1 the cycle after the final W handshake; bid=latched awid. Held until bready, then W_IDLE.

Read/write interaction:
- Same-cycle write and read-beat load to the same word: the read beat captures the pre-write value.
- Later beats see the write.

Test Plan:
- Reset released, single read: AR addr=0x40, len=0, size=3, READ_LATENCY=2, handshake at cycle 10 -> rvalid at cycle 12, rdata=mem[8], rlast=1, rresp=0, rid=arid; arready=1 again at cycle 13.
- Write burst: AW addr=0x100, len=3, id=5; 4 W beats 0xA..0xD, wstrb=0xFF, wlast on beat 3 -> mem[32..35]=0xA..0xD; bvalid the cycle after the last beat, bid=5, bresp=0.
- Partial strobe and backpressure: write 0x1122334455667788 with wstrb=0x0F over a word holding all-ones, then read len=0 with rready low 5 cycles -> rdata=0xFFFFFFFF55667788, held stable all 5 cycles.
- Errors: arburst=2'b10, len=1 -> 2 beats, rdata=0, rresp=2'b10, rlast on beat 1. Write len=3 with wlast on beat 1 -> bresp=2'b10 after beat 1; words 0,1 written, words 2,3 untouched.
- Wrap and FIXED: read INCR addr=(MEM_WORDS-1)*8, len=1 -> beats return mem[MEM_WORDS-1], mem[0]. FIXED len=2 -> the same word 3 times.
- Reset mid-burst: reset_n=0 during beat 2 of a len=7 read -> rvalid=0 next cycle, no further beats; after release, a new AR is accepted normally.
